// File: rtl/pipeline_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit_pkg
// Shared pipeline constants. The debug unit also uses this package, so the
// state encoding and the default widths are defined only here.
//   NB_REG_DEF    : register-address width
//   NB_CYCLES_DEF : cycle-counter width
//   state_t       : controller state codes, also visible on state_o
// ---------------------------------------------------------------------------
package pipeline_ctrl_unit_pkg;

  localparam int NB_REG_DEF    = 5;
  localparam int NB_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit_if
// Bundle of the request, hazard and control signals between the pipeline
// controller and the rest of the processor.
//   master : debug unit and datapath side. It drives the requests and hazard
//            inputs and observes the controls.
//   slave  : pipeline_ctrl_unit side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_unit_if
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_CYCLES = NB_CYCLES_DEF
);

  // Requests from the debug unit and hazard information from the datapath
  logic                  run_i;
  logic                  step_i;
  logic                  ex_mem_read_i;
  logic [NB_REG-1:0]     ex_rt_i;
  logic [NB_REG-1:0]     id_rs_i;
  logic [NB_REG-1:0]     id_rt_i;
  logic                  id_uses_rt_i;
  logic                  branch_taken_i;
  logic                  halt_wb_i;

  // Controls driven by the controller
  logic                  en_pipeline_o;
  logic                  pc_write_o;
  logic                  if_id_write_o;
  logic                  id_ex_bubble_o;
  logic                  if_id_flush_o;
  logic [1:0]            state_o;
  logic                  halted_o;
  logic [NB_CYCLES-1:0]  cycle_count_o;

  modport master (
    output run_i, step_i, ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i,
           id_uses_rt_i, branch_taken_i, halt_wb_i,
    input  en_pipeline_o, pc_write_o, if_id_write_o, id_ex_bubble_o,
           if_id_flush_o, state_o, halted_o, cycle_count_o
  );

  modport slave (
    input  run_i, step_i, ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i,
           id_uses_rt_i, branch_taken_i, halt_wb_i,
    output en_pipeline_o, pc_write_o, if_id_write_o, id_ex_bubble_o,
           if_id_flush_o, state_o, halted_o, cycle_count_o
  );

endinterface

// File: rtl/pipeline_ctrl_unit_hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Detects a load-use hazard. The load in ID/EX writes a register that the
// instruction in ID reads, so that instruction must wait one cycle.
//   ex_mem_read : ID/EX instruction is a load
//   ex_rt       : load destination register
//   id_rs/id_rt : source registers of the ID instruction
//   id_uses_rt  : ID instruction actually reads rt
//   load_use    : stall request (combinational)
// ---------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_use
);

  // Register 0 is hard-wired to zero, so a load into it never creates a
  // dependency.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit
// Top-level pipeline controller. It is a run/step/halt state machine driven
// by the debug unit. It gates the global pipeline enable, turns load-use
// hazards into stalls and bubbles, flushes IF/ID on taken branches, and
// counts the cycles in which the pipeline was enabled.
//   clock   : single clock, rising edge
//   reset_i : asynchronous, active-low reset
//   bus     : pipeline_ctrl_unit_if.slave (requests in, controls out)
// ---------------------------------------------------------------------------
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_CYCLES = NB_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset_i,
  pipeline_ctrl_unit_if.slave bus
);

  state_t               state_q, state_d;
  logic                 en_pipeline;
  logic                 load_use;
  logic [NB_CYCLES-1:0] cycle_count_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run_i)       state_d = ST_RUN;   // run wins over step
        else if (bus.step_i) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (bus.halt_wb_i)   state_d = ST_HALTED;
      end
      ST_STEP: begin
        state_d = bus.halt_wb_i ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;                     // only reset leaves
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The enable is a pure decode of the state register. Because nothing from
  // the inputs reaches it, a request pulse can never glitch the pipeline.
  assign en_pipeline = (state_q == ST_RUN) || (state_q == ST_STEP);

  // -------------------------------------------------------------------------
  // Enabled-cycle counter. It saturates so that a long run cannot read as a
  // short one.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i)
      cycle_count_q <= '0;
    else if (en_pipeline && (cycle_count_q != '1))
      cycle_count_q <= cycle_count_q + NB_CYCLES'(1);
  end

  // -------------------------------------------------------------------------
  // Hazard handling
  // -------------------------------------------------------------------------
  hazard_detect_unit #(.NB_REG(NB_REG)) u_hazard (
    .ex_mem_read (bus.ex_mem_read_i),
    .ex_rt       (bus.ex_rt_i),
    .id_rs       (bus.id_rs_i),
    .id_rt       (bus.id_rt_i),
    .id_uses_rt  (bus.id_uses_rt_i),
    .load_use    (load_use)
  );

  assign bus.en_pipeline_o  = en_pipeline;
  assign bus.pc_write_o     = en_pipeline && !load_use;
  assign bus.if_id_write_o  = en_pipeline && !load_use;
  assign bus.id_ex_bubble_o = en_pipeline &&  load_use;
  // A stalled branch keeps its IF/ID slot. Its operands are still in flight,
  // so it is re-evaluated next cycle instead of being flushed now.
  assign bus.if_id_flush_o  = en_pipeline && bus.branch_taken_i && !load_use;
  assign bus.state_o        = state_q;
  assign bus.halted_o       = (state_q == ST_HALTED);
  assign bus.cycle_count_o  = cycle_count_q;

endmodule

// File: doc/pipeline_ctrl_unit.md
PIPELINE_CTRL_UNIT -- requirements
Module: pipeline_ctrl_unit

Interface
REQ-001 Parameter NB_REG, 5, register-address width.
REQ-002 Parameter NB_CYCLES, 32, cycle-counter width.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 run_i  in  1  debug-unit request for continuous execution; one-cycle pulse.
REQ-006 step_i  in  1  debug-unit request for one pipeline advance; one-cycle pulse.
REQ-007 ex_mem_read_i  in  1  mem-read bit of the instruction currently in ID/EX.
REQ-008 ex_rt_i  in  NB_REG  destination register (register_b) of the ID/EX instruction.
REQ-009 id_rs_i, id_rt_i  in  NB_REG  source registers of the instruction in ID.
REQ-010 id_uses_rt_i  in  1  ID instruction reads rt (R-type, store, branch).
REQ-011 branch_taken_i  in  1  branch/jump resolved taken in ID.
REQ-012 halt_wb_i  in  1  halt instruction has reached WB.
REQ-013 en_pipeline_o  out  1  global pipeline-register enable.
REQ-014 pc_write_o  out  1  PC register write enable.
REQ-015 if_id_write_o  out  1  IF/ID register write enable.
REQ-016 id_ex_bubble_o  out  1  forces zero mem/wb/halt control into ID/EX.
REQ-017 if_id_flush_o  out  1  clears IF/ID instruction to NOP.
REQ-018 state_o  out  2  current state code.
REQ-019 halted_o  out  1  program finished.
REQ-020 cycle_count_o  out  NB_CYCLES  enabled cycles executed.

Function
REQ-021 States: IDLE=00, RUN=01, STEP=10, HALTED=11; Moore state register.
REQ-022 IDLE: run_i -> RUN; else step_i -> STEP; run_i takes priority when both asserted.
REQ-023 RUN: halt_wb_i -> HALTED; else remain RUN; run_i/step_i ignored.
REQ-024 STEP: lasts exactly one cycle; halt_wb_i -> HALTED, else -> IDLE.
REQ-025 HALTED: terminal; leaves only via reset.
REQ-026 en_pipeline_o = 1 iff state is RUN or STEP; pure decode of the state register, no combinational path from inputs.
REQ-027 halted_o = 1 iff state is HALTED.
REQ-028 load_use = ex_mem_read_i AND ex_rt_i != 0 AND (ex_rt_i == id_rs_i OR (id_uses_rt_i AND ex_rt_i == id_rt_i)).
REQ-029 When en_pipeline_o = 1 and load_use = 1: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1, same cycle (combinational).
REQ-030 When en_pipeline_o = 1 and load_use = 0: pc_write_o = 1, if_id_write_o = 1, id_ex_bubble_o = 0.
REQ-031 When en_pipeline_o = 0: pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o all 0.
REQ-032 if_id_flush_o = en_pipeline_o AND branch_taken_i AND NOT load_use; a stalled branch is not flushed (its operands are not yet valid).
REQ-033 cycle_count_o increments by 1 on every rising edge with en_pipeline_o = 1; saturates at all-ones, no wrap.
REQ-034 halt_wb_i in IDLE or HALTED has no effect.

Reset
REQ-035 Asserting reset_i (low) immediately forces state IDLE, cycle_count_o 0, halted_o 0, en_pipeline_o 0, independent of clock.
REQ-036 Reset mid-RUN or mid-STEP aborts without completing the cycle; no further enable pulses until a new run_i/step_i.
REQ-037 Reset deassertion is taken synchronously into the state machine; first transition possible on the next rising edge.

Structure
REQ-038 State codes and NB_REG/NB_CYCLES defaults live in the shared pipeline constants package, reused by the debug unit.
REQ-039 Hazard comparison (REQ-028) is a sub-module hazard_detect_unit; state machine and counter stay in pipeline_ctrl_unit.

Verification
REQ-040 Reset low, then high; step_i pulse -> en_pipeline_o high exactly one cycle, state 00->10->00, cycle_count_o = 1.
REQ-041 run_i pulse, halt_wb_i after 10 cycles -> en_pipeline_o high 10 cycles, state 11, halted_o = 1, cycle_count_o = 10; later run_i ignored.
REQ-042 RUN, ex_mem_read_i = 1, ex_rt_i = 8, id_rs_i = 8 -> pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1; repeat with ex_rt_i = 0 -> no stall.
REQ-043 RUN, ex_rt_i = 9 = id_rt_i, id_uses_rt_i = 0 -> no stall; id_uses_rt_i = 1 -> stall.
REQ-044 RUN, branch_taken_i = 1 with no load_use -> if_id_flush_o = 1; with load_use -> if_id_flush_o = 0, bubble = 1.
REQ-045 reset_i low mid-RUN between clock edges -> en_pipeline_o and cycle_count_o drop to 0 before the next edge; run_i and step_i together in IDLE -> RUN.
